wb_stage_pipe: RTL

Parametrised writeback stage for the MIPS pipeline; the next generation of the fixed four-bit control register stage. It registers the MEM/WB bundle with valid, hold and flush control, and selects the register-file write data from the ALU, memory or link sources. It drives single-shot register-file and HI/LO write strobes, plus a same-cycle forwarding tap for the hazard unit. It sits between the MEM stage and the register file / HI-LO registers.

---
 rtl/mips_pkg.sv | 11 +
 rtl/wb_data_sel.sv | 23 ++
 rtl/wb_stage_pipe.sv | 134 +++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: writeback source encoding and default widths.
package mips_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_AW = 5;

  localparam logic [1:0] WB_SRC_ALU  = 2'd0;
  localparam logic [1:0] WB_SRC_MEM  = 2'd1;
  localparam logic [1:0] WB_SRC_LINK = 2'd2;

endpackage

// File: rtl/wb_data_sel.sv
// Writeback data source mux; the reserved encoding falls back to the ALU result.
module wb_data_sel
  import mips_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [1:0]        wb_sel,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] link_addr,
  output logic [DATA_W-1:0] wdata
);

  always_comb begin
    wdata = alu_result;
    case (wb_sel)
      WB_SRC_MEM:  wdata = mem_data;
      WB_SRC_LINK: wdata = link_addr;
      default:     wdata = alu_result;
    endcase
  end

endmodule

// File: rtl/wb_stage_pipe.sv
// MEM/WB stage register with hold/flush and single-shot writeback strobes.
// Optional retire counter and retire_count port enabled by WB_RETIRE_CNT_EN.
module wb_stage_pipe
  import mips_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW
`ifdef WB_RETIRE_CNT_EN
  ,
  parameter int CNT_W  = 32
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              hold,
  input  logic              flush,
  input  logic              rf_en,
  input  logic              ta_instr,
  input  logic              hi_en,
  input  logic              lo_en,
  input  logic [1:0]        wb_sel,
  input  logic [REG_AW-1:0] dest,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] link_addr,
  input  logic [DATA_W-1:0] hi_data,
  input  logic [DATA_W-1:0] lo_data,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              hi_we,
  output logic              lo_we,
  output logic [DATA_W-1:0] hi_wdata,
  output logic [DATA_W-1:0] lo_wdata,
  output logic              ta_instr_out,
  output logic              wb_valid,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_addr,
  output logic [DATA_W-1:0] fwd_data
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0]  retire_count
`endif
);

  logic              valid_q;
  logic              done_q;
  logic              rf_en_q;
  logic              ta_q;
  logic              hi_en_q;
  logic              lo_en_q;
  logic [REG_AW-1:0] dest_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  logic [DATA_W-1:0] sel_data;

  wb_data_sel #(.DATA_W(DATA_W)) u_data_sel (
    .wb_sel    (wb_sel),
    .alu_result(alu_result),
    .mem_data  (mem_data),
    .link_addr (link_addr),
    .wdata     (sel_data)
  );

  // done marks that the first visible cycle has passed, so a held instruction writes once
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      rf_en_q <= 1'b0;
      ta_q    <= 1'b0;
      hi_en_q <= 1'b0;
      lo_en_q <= 1'b0;
      dest_q  <= '0;
      wdata_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else if (hold) begin
      done_q  <= done_q | valid_q;
    end else begin
      valid_q <= in_valid;
      done_q  <= 1'b0;
      rf_en_q <= rf_en;
      ta_q    <= ta_instr;
      hi_en_q <= hi_en;
      lo_en_q <= lo_en;
      dest_q  <= dest;
      wdata_q <= sel_data;
      hi_q    <= hi_data;
      lo_q    <= lo_data;
    end
  end

  logic first_vis;
  logic rf_live;

  assign first_vis    = valid_q & ~done_q;
  assign rf_live      = valid_q & rf_en_q & (dest_q != '0);

  assign in_ready     = ~hold;
  assign rf_we        = rf_live & ~done_q;
  assign rf_waddr     = dest_q;
  assign rf_wdata     = wdata_q;
  assign hi_we        = first_vis & hi_en_q;
  assign lo_we        = first_vis & lo_en_q;
  assign hi_wdata     = hi_q;
  assign lo_wdata     = lo_q;
  assign ta_instr_out = valid_q & ta_q;
  assign wb_valid     = valid_q;
  assign fwd_valid    = rf_live;
  assign fwd_addr     = dest_q;
  assign fwd_data     = wdata_q;

`ifdef WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (first_vis) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign retire_count = cnt_q;
`endif

endmodule
